soc_memory: RTL and testbench
=============================

SOC_MEMORY -- requirements
Module: soc_memory

Interface
REQ-001 Parameter MEM_WORDS, default 1024: number of 64-bit RAM words; power of two.
REQ-002 Parameter FIFO_DEPTH, default 8: UART transmit FIFO entries; power of two, at least 2.
REQ-003 Parameter CLK_DIV, default 16: clk cycles per UART bit; at least 2.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 mem_addr  input  64  byte address from the CPU.
REQ-007 mem_data  inout  64  bidirectional data bus; this block drives it only while rw=0 and is high-Z while rw=1.
REQ-008 mem_mask  input  8  byte-lane write enables; bit i controls mem_data[8i+7:8i].
REQ-009 rw  input  1  0 = read, 1 = write.
REQ-010 uart_tx  output  1  serial transmit line, 8N1, idle high.

Function
REQ-011 Address decode: mem_addr[31]=0 selects RAM at word index mem_addr[log2(MEM_WORDS)+2:3]; mem_addr[31]=1 selects IO; mem_addr[2:0] is ignored for decode.
REQ-012 RAM read is combinational: while rw=0, mem_data equals the addressed word in the same cycle the address is applied, giving zero-cycle latency.
REQ-013 RAM write: on every rising edge with rw=1 and RAM selected, each byte lane with mem_mask[i]=1 is updated and unmasked lanes are unchanged; repeated cycles of the same write are idempotent.
REQ-014 RAM addresses with word index >= MEM_WORDS read as 0; writes to them are discarded.
REQ-015 Write strobe wstb = rw & ~rw_q, where rw_q is rw registered. IO side effects occur only on wstb, so a store held for several cycles acts once.
REQ-016 IO 0x8000_0000 (UART DATA): wstb with mem_mask[0]=1 pushes mem_data[7:0] into the FIFO; a read returns 0.
REQ-017 IO 0x8000_0008 (UART STATUS): read returns bit0=FIFO full, bit1=transmitter busy, bit2=overflow sticky, bits[15:8]=FIFO count, all other bits 0; wstb to this address clears overflow.
REQ-018 Any other IO address reads 0; writes to it are ignored.
REQ-019 FIFO: circular buffer with read and write pointers that wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
REQ-020 Push while full with no simultaneous pop: byte is dropped and overflow is set.
REQ-021 Simultaneous push and pop when full: both occur, count is unchanged, and overflow is not set.
REQ-022 Transmitter FSM states: IDLE, START, DATA, STOP.
REQ-023 IDLE: if the FIFO is non-empty, pop the head into a shift register and go to START on the next edge.
REQ-024 START drives 0; DATA drives 8 bits LSB first; STOP drives 1.
REQ-025 Every bit, including start and stop, lasts exactly CLK_DIV cycles, timed by a baud counter that reloads on each bit boundary.
REQ-026 STOP returns to IDLE; back-to-back bytes therefore have no extra idle bits.
REQ-027 busy = (state != IDLE).
REQ-028 uart_tx is registered and glitch-free; it is 1 in IDLE and STOP.

Reset
REQ-029 While reset=0, asynchronously: FSM=IDLE, uart_tx=1, FIFO pointers and count=0, overflow=0, rw_q=0, baud counter=0.
REQ-030 Reset mid-frame aborts the frame immediately (uart_tx=1) and discards all queued bytes.
REQ-031 RAM contents are not affected by reset.
REQ-032 The first wstb is recognised on the first write cycle after reset deasserts.

Configuration
REQ-033 Macro SOC_UART_EN defined: UART, FIFO and IO registers are present as specified.
REQ-034 Macro SOC_UART_EN undefined: no FIFO or FSM logic; uart_tx is tied to 1; all IO reads return 0 and IO writes are ignored; RAM behaviour is unchanged.

Verification
REQ-035 Write 0x1122334455667788 to 0x10 with mask 0xFF, then write 0xAA with mask 0x04 -> reading 0x10 returns 0x1122334455AA7788.
REQ-036 Read 0x2000 (word index 1024, MEM_WORDS=1024) -> returns 0; a prior write there leaves RAM index 0 unchanged.
REQ-037 Hold a write of 0x41 to 0x8000_0000 for 3 cycles (rw=1) -> exactly 1 byte is transmitted; with CLK_DIV=16, uart_tx shows start 0, then 1,0,0,0,0,0,1,0, then stop 1, each bit 16 cycles, for 160 cycles total.
REQ-038 Push 10 bytes while the transmitter is busy (FIFO_DEPTH=8) -> status bit0=1, bit2=1; a wstb to 0x8000_0008 clears bit2; the frames sent are the first byte plus the next 8 queued.
REQ-039 Assert reset during the DATA bit 3 of a frame with 2 bytes queued -> uart_tx=1 within the same cycle; status reads 0; no further frames are sent.
REQ-040 Build without SOC_UART_EN and write 0x55 to 0x8000_0000 -> uart_tx stays 1 for 500 cycles; status reads 0.

Source files
------------

// File: rtl/soc_memory.sv
// 64-bit CPU memory port: combinational-read RAM plus a memory-mapped 8N1 UART transmitter.
// Define SOC_UART_EN to build the UART, its FIFO and IO registers; otherwise IO space reads 0.
module soc_memory #(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CLK_DIV    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] mem_addr,
  inout  wire  [63:0] mem_data,
  input  logic [7:0]  mem_mask,
  input  logic        rw,
  output logic        uart_tx
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  logic [63:0]   ram [MEM_WORDS];
  logic          ram_sel;
  logic          in_range;
  logic [AW-1:0] word_idx;
  logic [63:0]   io_rdata;
  logic [63:0]   rdata;
  logic          unused_addr;

  assign ram_sel     = ~mem_addr[31];
  assign word_idx    = mem_addr[AW+2:3];
  assign in_range    = (mem_addr[30:AW+3] == '0);
  assign unused_addr = ^{mem_addr[63:32], mem_addr[2:0]};

  always_ff @(posedge clk) begin
    if (rw && ram_sel && in_range) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (mem_mask[i]) ram[word_idx][8*i +: 8] <= mem_data[8*i +: 8];
      end
    end
  end

  assign rdata    = ram_sel ? (in_range ? ram[word_idx] : '0) : io_rdata;
  assign mem_data = rw ? 'z : rdata;

`ifdef SOC_UART_EN
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = $clog2(CLK_DIV);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  tx_state_t   state, state_n;
  logic        rw_q, wstb;
  logic [7:0]  fifo [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic        full, empty, push_req, push, pop, overflow, busy;
  logic        data_sel, status_sel;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shreg, shreg_n;
  logic        tx_n;

  assign wstb       = rw & ~rw_q;
  assign data_sel   = mem_addr[31] && (mem_addr[30:3] == '0);
  assign status_sel = mem_addr[31] && (mem_addr[30:3] == 28'd1);
  assign full       = (count == (PW+1)'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign busy       = (state != IDLE);
  assign push_req   = wstb & data_sel & mem_mask[0];
  // A push into a full FIFO is still accepted when the transmitter pops the head in the same cycle.
  assign push       = push_req & (~full | pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rw_q     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      rw_q <= rw;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wstb && status_sel)           overflow <= 1'b0;
      else if (push_req && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= mem_data[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      uart_tx <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      uart_tx <= tx_n;
    end
  end

  // STOP is timed one cycle short: the IDLE cycle that follows supplies the last stop-bit cycle,
  // so every bit is CLK_DIV long and back-to-back frames carry no extra idle time.
  always_comb begin
    state_n   = state;
    baud_n    = baud;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    tx_n      = uart_tx;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shreg_n = fifo[rd_ptr];
          state_n = START;
          baud_n  = BW'(CLK_DIV - 1);
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (baud == '0) begin
          state_n   = DATA;
          baud_n    = BW'(CLK_DIV - 1);
          bit_idx_n = '0;
          tx_n      = shreg[0];
        end else begin
          baud_n = baud - 1'b1;
        end
      end
      DATA: begin
        if (baud == '0) begin
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            baud_n  = BW'(CLK_DIV - 2);
            tx_n    = 1'b1;
          end else begin
            baud_n    = BW'(CLK_DIV - 1);
            bit_idx_n = bit_idx + 1'b1;
            shreg_n   = shreg >> 1;
            tx_n      = shreg[1];
          end
        end else begin
          baud_n = baud - 1'b1;
        end
      end
      STOP: begin
        tx_n = 1'b1;
        if (baud == '0) state_n = IDLE;
        else            baud_n  = baud - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    io_rdata = '0;
    if (status_sel) io_rdata = {48'b0, 8'(count), 5'b0, overflow, busy, full};
  end
`else
  logic unused_reset;

  assign io_rdata     = '0;
  assign uart_tx      = 1'b1;
  assign unused_reset = reset;
`endif

endmodule

// File: tb/tb_soc_memory.sv
// Self-checking bench for soc_memory: byte-level RAM model, UART frame decoder and FIFO occupancy model.
module tb_soc_memory;
  localparam int unsigned MEM_WORDS  = 1024;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned CLK_DIV    = 16;
  localparam time         TCLK       = 10;
  localparam logic [63:0] UART_DATA  = 64'h8000_0000;
  localparam logic [63:0] UART_STAT  = 64'h8000_0008;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] mem_addr;
  logic [7:0]  mem_mask;
  logic        rw;
  logic [63:0] wdata;
  wire  [63:0] mem_data;
  logic        uart_tx;

  int checks = 0;
  int errors = 0;

  assign mem_data = rw ? wdata : 'z;
  always #(TCLK/2) clk = ~clk;

  soc_memory #(.MEM_WORDS(MEM_WORDS), .FIFO_DEPTH(FIFO_DEPTH), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_mask(mem_mask), .rw(rw), .uart_tx(uart_tx)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Byte-addressed RAM reference
  logic [7:0] mbyte [MEM_WORDS*8];

  function automatic logic [63:0] model_read(input logic [63:0] a);
    int unsigned wi;
    logic [63:0] r;
    wi = int'(a[30:3]);
    r  = '0;
    if (a[31] || wi >= MEM_WORDS) return '0;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = mbyte[wi*8 + k];
    return r;
  endfunction

  task automatic model_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] m);
    int unsigned wi;
    wi = int'(a[30:3]);
    if (!a[31] && wi < MEM_WORDS)
      for (int k = 0; k < 8; k++) if (m[k]) mbyte[wi*8 + k] = d[8*k +: 8];
  endtask

  task automatic bus_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] m, input int hold);
    mem_addr = a;
    wdata    = d;
    mem_mask = m;
    rw       = 1'b1;
    cyc(hold);
    rw = 1'b0;
    model_write(a, d, m);
    cyc(1);
  endtask

  task automatic bus_read(input logic [63:0] a, output logic [63:0] d);
    mem_addr = a;
    rw       = 1'b0;
    #1;
    d = mem_data;
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return d[k-1];
  endfunction

  // Serial decoder: samples each bit cell at its midpoint; a reset abandons the frame.
  logic [7:0] rx_q [$];
  time        start_t = 0;
  logic       mon_ok;
  logic [9:0] mon_bits;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && uart_tx === 1'b0) begin
        start_t = $time;
        mon_ok  = 1'b1;
        for (int i = 0; i < 10; i++) begin
          repeat ((i == 0) ? CLK_DIV/2 : CLK_DIV) begin
            @(negedge clk);
            if (reset !== 1'b1) mon_ok = 1'b0;
          end
          if (!mon_ok) break;
          mon_bits[i] = uart_tx;
        end
        if (mon_ok) begin
          check("frame_start", 64'(mon_bits[0]), 64'd0);
          check("frame_stop", 64'(mon_bits[9]), 64'd1);
          rx_q.push_back(mon_bits[8:1]);
        end
      end
    end
  end

  task automatic wait_rx(input int n, input int budget);
    int c;
    c = 0;
    while (rx_q.size() < n && c < budget) begin
      cyc(1);
      c++;
    end
    check("rx_count", 64'(rx_q.size()), 64'(n));
  endtask

  initial begin : watchdog
    #(TCLK * 100000);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [63:0] a, d, ram0;
    logic [7:0]  b, expq [$];
    int          base, n, mc;
    logic        ovf_exp;

    rw = 1'b0; mem_addr = '0; mem_mask = '0; wdata = '0; reset = 1'b0;
    cyc(3);
    check("reset_tx", 64'(uart_tx), 64'd1);
    bus_read(UART_STAT, d);
    check("reset_status", d, 64'd0);
    cyc(1);
    reset = 1'b1;
    cyc(2);

    for (int i = 0; i < 64; i++) bus_write(64'(i*8), {$urandom, $urandom}, 8'hFF, 1);
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) a = 64'(32'h2000 | ($urandom & 32'h7FFF_FFFF));
      else                           a = 64'($urandom_range(0, 63) * 8 + $urandom_range(0, 7));
      bus_write(a, {$urandom, $urandom}, 8'($urandom), int'($urandom_range(1, 3)));
    end
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) a = 64'(32'h2000 | ($urandom & 32'h7FFF_FFFF));
      else                           a = 64'($urandom_range(0, 63) * 8 + $urandom_range(0, 7));
      bus_read(a, d);
      check("ram_rand", d, model_read(a));
    end

    bus_write(64'h10, 64'h1122_3344_5566_7788, 8'hFF, 1);
    bus_write(64'h10, 64'h0000_0000_00AA_0000, 8'h04, 1);
    bus_read(64'h10, d);
    check("ram_lane_merge", d, 64'h1122_3344_55AA_7788);
    bus_read(64'h17, d);
    check("ram_low_bits_ignored", d, 64'h1122_3344_55AA_7788);
    ram0 = model_read(64'h0);
    bus_write(64'h2000, {$urandom, $urandom}, 8'hFF, 1);
    bus_read(64'h2000, d);
    check("ram_oob_read", d, 64'd0);
    bus_read(64'h0, d);
    check("ram_oob_no_alias", d, ram0);
    check("tx_idle_after_ram", 64'(uart_tx), 64'd1);

`ifdef SOC_UART_EN
    // Held store of 0x41: single frame, exact waveform
    base = rx_q.size();
    mem_addr = UART_DATA; wdata = 64'h41; mem_mask = 8'h01; rw = 1'b1;
    for (int j = 1; j <= 175; j++) begin
      cyc(1);
      if (j < 2 || j - 2 >= 160) check("tx_wave", 64'(uart_tx), 64'd1);
      else check("tx_wave", 64'(uart_tx), 64'(frame_bit(8'h41, (j - 2) / 16)));
      if (j == 3) rw = 1'b0;
    end
    cyc(1);
    wait_rx(base + 1, 400);
    if (rx_q.size() > base) check("rx_held_byte", 64'(rx_q[base]), 64'h41);

    // Random sparse pushes, never filling the FIFO
    base = rx_q.size();
    expq.delete();
    bus_write(UART_DATA, 64'($urandom), 8'hFE, 1);
    n = int'($urandom_range(3, 5));
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      expq.push_back(b);
      bus_write(UART_DATA, {$urandom, 24'($urandom), b}, {7'($urandom), 1'b1}, int'($urandom_range(1, 3)));
      cyc(int'($urandom_range(0, 40)));
    end
    bus_read(UART_STAT, d);
    check("no_overflow", 64'(d[2]), 64'd0);
    wait_rx(base + n, n * CLK_DIV * 10 + 200);
    for (int i = 0; i < n; i++)
      if (base + i < rx_q.size()) check("rx_rand_byte", 64'(rx_q[base + i]), 64'(expq[i]));
    cyc(20);
    bus_read(UART_STAT, d);
    check("status_drained", d, 64'd0);

    // Overflow: ten pushes while the transmitter is busy
    base = rx_q.size();
    expq.delete();
    b = 8'($urandom);
    expq.push_back(b);
    bus_write(UART_DATA, 64'(b), 8'h01, 1);
    mc = 0;
    ovf_exp = 1'b0;
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      bus_write(UART_DATA, 64'(b), 8'h01, 1);
      if (mc < FIFO_DEPTH) begin
        expq.push_back(b);
        mc++;
      end else begin
        ovf_exp = 1'b1;
      end
    end
    bus_read(UART_STAT, d);
    check("status_overflow", d, (64'(mc) << 8) | (64'(ovf_exp) << 2) | 64'h2 | 64'(mc == FIFO_DEPTH));
    bus_write(UART_STAT, 64'd0, 8'hFF, 1);
    bus_read(UART_STAT, d);
    check("status_ovf_cleared", d, (64'(mc) << 8) | 64'h2 | 64'(mc == FIFO_DEPTH));
    wait_rx(base + 1 + mc, (mc + 1) * CLK_DIV * 10 + 200);
    for (int i = 0; i <= mc; i++)
      if (base + i < rx_q.size()) check("rx_ovf_byte", 64'(rx_q[base + i]), 64'(expq[i]));
    cyc(20);
    bus_read(UART_STAT, d);
    check("status_after_ovf", d, 64'd0);

    // Reset during data bit 3 with two bytes queued
    start_t = 0;
    bus_write(UART_DATA, 64'($urandom & 32'hF7), 8'h01, 1);
    bus_write(UART_DATA, 64'($urandom), 8'h01, 1);
    bus_write(UART_DATA, 64'($urandom), 8'h01, 1);
    n = 0;
    while ((start_t == 0 || $time < start_t + TCLK * 72) && n < 200) begin
      cyc(1);
      n++;
    end
    check("tx_in_bit3", 64'(uart_tx), 64'd0);
    #2;
    reset = 1'b0;
    #1;
    check("tx_abort", 64'(uart_tx), 64'd1);
    bus_read(UART_STAT, d);
    check("status_in_reset", d, 64'd0);
    cyc(2);
    reset = 1'b1;
    base = rx_q.size();
    for (int i = 0; i < 400; i++) begin
      cyc(1);
      check("tx_quiet", 64'(uart_tx), 64'd1);
    end
    check("no_frames_after_reset", 64'(rx_q.size()), 64'(base));
    bus_read(UART_STAT, d);
    check("status_after_reset", d, 64'd0);

    // Unmapped IO and register readback
    bus_write(64'h8000_0010, {$urandom, $urandom}, 8'hFF, 1);
    bus_read(64'h8000_0010, d);
    check("io_unmapped_read", d, 64'd0);
    bus_read(UART_DATA, d);
    check("io_data_read", d, 64'd0);
    bus_read(UART_STAT, d);
    check("io_unmapped_write", d, 64'd0);

    // First store after reset release is recognised
    base = rx_q.size();
    b = 8'($urandom);
    bus_write(UART_DATA, 64'(b), 8'h01, 2);
    wait_rx(base + 1, CLK_DIV * 10 + 100);
    if (rx_q.size() > base) check("rx_post_reset", 64'(rx_q[base]), 64'(b));
`else
    bus_write(UART_DATA, 64'h55, 8'hFF, 1);
    for (int i = 0; i < 500; i++) begin
      cyc(1);
      check("tx_disabled", 64'(uart_tx), 64'd1);
    end
    bus_read(UART_STAT, d);
    check("status_disabled", d, 64'd0);
    bus_read(UART_DATA, d);
    check("data_disabled", d, 64'd0);
    bus_read(64'h10, d);
    check("ram_after_io", d, 64'h1122_3344_55AA_7788);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
